mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1, 2-bit data mux.
- Four requesters compete for a single output channel. The block grants one requester at a time and drives the mux select register.
- It forwards the selected requester's data to a valid/ready consumer. A grant is bounded to HOLD_MAX beats so no requester can starve the others.

Parameters:
- WIDTH, 2: data width of each input and of out_data.
- HOLD_MAX, 4: maximum beats transferred per grant, legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  request per requester; req[i] belongs to in_i.
- in0  in  WIDTH  requester 0 data.
- in1  in  WIDTH  requester 1 data.
- in2  in  WIDTH  requester 2 data.
- in3  in  WIDTH  requester 3 data.
- out_ready  in  1  consumer accepts a beat this cycle.
- select  out  2  registered mux select, equal to the index of the current or last grantee.
- gnt  out  4  registered one-hot grant; all zero when idle.
- out_valid  out  1  beat presented on out_data.
- out_data  out  WIDTH  selected requester data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, select=0, gnt=0, last_winner=3, beat_cnt=0.
  - out_valid=0, out_data=0.
  - Reset mid-burst aborts the grant immediately; no partial-state carry-over.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, choose the first set req bit scanning from last_winner+1 mod 4 upward with wrap.
  - On the next edge: select<=winner, gnt<=onehot(winner), beat_cnt<=0, state<=GRANT.
  - If req == 0, stay in IDLE with gnt=0 and select holding its value.
- GRANT:
  - out_valid = req[select] (combinational from registered select).
  - out_data = in[select] when out_valid=1, else 0.
  - Transfer = out_valid & out_ready; each transfer increments beat_cnt.
- Release conditions, evaluated each GRANT cycle:
  - (a) req[select]=0, or
  - (b) a transfer occurs with beat_cnt==HOLD_MAX-1.
  - On release, at the next edge: state<=IDLE, gnt<=0, last_winner<=select, beat_cnt<=0.
- Latency and turnaround:
  - A req first sampled high in IDLE at edge N gives gnt at edge N; the first beat can transfer in the cycle following edge N.
  - There is one mandatory idle cycle between consecutive grants, including re-grant of the same requester.
- Handshake rules:
  - A granted requester holds its in_i stable and req[i] high while out_valid=1 and out_ready=0.
  - Dropping req while stalled is legal and releases the grant with no transfer.
- Requests from non-granted requesters are ignored during GRANT; they are not latched. Arbitration uses req sampled in IDLE only.
- Fairness:
  - After a grant to i, priority order is i+1, i+2, i+3, i (mod 4).
  - With all four requesting continuously, the grant order is 0,1,2,3,0,...
- Simultaneous events:
  - Transfer with beat_cnt==HOLD_MAX-1 and req dropping in the same cycle: the beat counts, then the grant releases (single release).
  - out_ready is a don't-care when out_valid=0.
- beat_cnt is a 4-bit register and never exceeds HOLD_MAX-1.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-GRANT with req=4'b1111 → gnt=0, out_valid=0, select=0 immediately. After release, the first grant goes to requester 0.
- Single requester: req=4'b0100, in2=2'b10, out_ready=1 → gnt=4'b0100 one cycle later, select=2. Four beats of 2'b10, then one IDLE cycle, then re-grant to 2.
- Full contention: req=4'b1111, out_ready=1, HOLD_MAX=4 → grants rotate 0,1,2,3,0. Each grant carries exactly 4 beats followed by 1 idle cycle.
- Backpressure: grant requester 1, in1=2'b01, out_ready low for 3 cycles → out_valid stays 1 and out_data stays 2'b01. beat_cnt does not advance until out_ready=1.
- Early drop: grant requester 3, deassert req[3] after 2 beats while req[0] is high → release; the next grant goes to 0 after one idle cycle.
- Wrap priority: last_winner=2 with req=4'b0101 → grant to 0, not 2. Next, with req=4'b0101 → grant to 2.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin grant sequencer for the shared 4:1 data mux.
// Each grant is bounded to HOLD_MAX beats; one idle cycle separates grants.
module mux_rr_arbiter #(
   parameter int WIDTH    = 2,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic             out_ready,
   output logic [1:0]       select,
   output logic [3:0]       gnt,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);

   state_t           state;
   logic [1:0]       last_winner;
   logic [3:0]       beat_cnt;
   logic [1:0]       winner;
   logic [WIDTH-1:0] sel_data;
   logic             xfer;
   logic             rel;

   // first requester after last_winner, wrapping; ties never occur
   always_comb begin
      logic [1:0] idx;
      logic       found;
      winner = last_winner + 2'd1;
      found  = 1'b0;
      idx    = last_winner;
      for (int k = 1; k <= 4; k++) begin
         idx = last_winner + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      unique case (select)
         2'd0: sel_data = in0;
         2'd1: sel_data = in1;
         2'd2: sel_data = in2;
         2'd3: sel_data = in3;
      endcase
   end

   assign out_valid = (state == GRANT) && req[select];
   assign out_data  = out_valid ? sel_data : '0;
   assign xfer      = out_valid && out_ready;
   assign rel       = !req[select] ||
                      (xfer && (beat_cnt == LAST_BEAT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         select      <= 2'd0;
         gnt         <= 4'b0000;
         last_winner <= 2'd3;
         beat_cnt    <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  select   <= winner;
                  gnt      <= 4'b0001 << winner;
                  beat_cnt <= 4'd0;
                  state    <= GRANT;
               end else begin
                  gnt <= 4'b0000;
               end
            end
            GRANT: begin
               if (rel) begin
                  state       <= IDLE;
                  gnt         <= 4'b0000;
                  last_winner <= select;
                  beat_cnt    <= 4'd0;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + 4'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-free round-robin model.
module tb_mux_rr_arbiter;

   localparam int W    = 2;
   localparam int HOLD = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req;
   logic [W-1:0] in0, in1, in2, in3;
   logic         out_ready;
   logic [1:0]   select;
   logic [3:0]   gnt;
   logic         out_valid;
   logic [W-1:0] out_data;

   int vectors = 0;
   int miscompares = 0;

   bit m_busy;
   int m_sel;
   int m_last;
   int m_beats;

   always #5 clk = ~clk;

   mux_rr_arbiter #(
      .WIDTH(W),
      .HOLD_MAX(HOLD)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .in0(in0),
      .in1(in1),
      .in2(in2),
      .in3(in3),
      .out_ready(out_ready),
      .select(select),
      .gnt(gnt),
      .out_valid(out_valid),
      .out_data(out_data)
   );

   task automatic chk(input string n, input logic [7:0] act,
                      input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  n, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] din(input int i);
      case (i)
         0: return in0;
         1: return in1;
         2: return in2;
         default: return in3;
      endcase
   endfunction

   // model: compare outputs, then advance on the inputs the next edge sees
   always @(negedge clk) begin
      logic [3:0]   e_gnt;
      logic         e_v;
      logic [W-1:0] e_d;
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_sel   = 0;
         m_last  = 3;
         m_beats = 0;
      end
      e_v   = m_busy && req[m_sel];
      e_gnt = m_busy ? 4'(1 << m_sel) : 4'b0000;
      e_d   = e_v ? din(m_sel) : '0;
      chk("gnt", 8'(gnt), 8'(e_gnt));
      chk("select", 8'(select), 8'(m_sel));
      chk("out_valid", 8'(out_valid), 8'(e_v));
      chk("out_data", 8'(out_data), 8'(e_d));
      if (rst_n) begin
         if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
               int c;
               c = (m_last + k) % 4;
               if (!m_busy && req[c]) begin
                  m_busy  = 1'b1;
                  m_sel   = c;
                  m_beats = 0;
               end
            end
         end else if (!req[m_sel]) begin
            m_busy = 1'b0;
            m_last = m_sel;
         end else if (out_ready) begin
            m_beats++;
            if (m_beats == HOLD) begin
               m_busy = 1'b0;
               m_last = m_sel;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // called 1 time unit after an edge; reset spans the following negedge
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_gnt", 8'(gnt), 8'h00);
      chk("rst_valid", 8'(out_valid), 8'h00);
      chk("rst_select", 8'(select), 8'h00);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      req = '0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single requester 2
      req = 4'b0100; in2 = 2'b10; out_ready = 1'b1;
      cyc(1);
      chk("single_gnt", 8'(gnt), 8'h04);
      chk("single_sel", 8'(select), 8'h02);
      for (int i = 0; i < 4; i++) begin
         chk("single_beat", 8'({out_valid, out_data}), 8'h06);
         cyc(1);
      end
      chk("single_idle", 8'(gnt), 8'h00);
      cyc(1);
      chk("single_regrant", 8'(gnt), 8'h04);

      // reset mid-grant under full request
      req = 4'b1111;
      cyc(2);
      do_reset();

      // full contention: 4 beats per grant, 1 idle, order 0,1,2,3,0
      for (int i = 0; i < 21; i++) begin
         logic [3:0] e;
         cyc(1);
         e = (i % 5 == 4) ? 4'b0000 : 4'(1 << ((i / 5) % 4));
         chk("rr_gnt", 8'(gnt), 8'(e));
      end

      // backpressure on requester 1
      do_reset();
      req = 4'b0010; in1 = 2'b01; out_ready = 1'b0;
      cyc(1);
      chk("bp_gnt", 8'(gnt), 8'h02);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold", 8'({out_valid, out_data}), 8'h05);
         cyc(1);
      end
      out_ready = 1'b1;
      cyc(3);
      chk("bp_3beats", 8'(gnt), 8'h02);
      cyc(1);
      chk("bp_release", 8'(gnt), 8'h00);

      // early drop by requester 3 while 0 waits
      req = 4'b1001; in3 = 2'b11; in0 = 2'b00;
      cyc(1);
      chk("drop_gnt3", 8'(gnt), 8'h08);
      cyc(2);
      req = 4'b0001;
      cyc(1);
      chk("drop_idle", 8'(gnt), 8'h00);
      cyc(1);
      chk("drop_gnt0", 8'(gnt), 8'h01);

      // make 2 the last winner, then check wrap priority
      req = 4'b0100;
      cyc(2);
      chk("wrap_gnt2", 8'(gnt), 8'h04);
      req = 4'b0000;
      cyc(1);
      req = 4'b0101;
      cyc(1);
      chk("wrap_gnt0", 8'(gnt), 8'h01);
      cyc(4);
      chk("wrap_idle", 8'(gnt), 8'h00);
      cyc(1);
      chk("wrap_next2", 8'(gnt), 8'h04);

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         req       = 4'($urandom_range(15));
         if ($urandom_range(3) == 0) req = 4'b0000;
         out_ready = ($urandom_range(9) < 7);
         in0 = W'($urandom); in1 = W'($urandom);
         in2 = W'($urandom); in3 = W'($urandom);
         if ($urandom_range(199) == 0) do_reset();
         cyc(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
